// File: rtl/dcm_pkg.sv
// rtl/dcm_pkg.sv - shared bounds, widths, lock-state type and config check for the CLKFX synthesizer
package dcm_pkg;

   localparam int M_MIN  = 1;
   localparam int M_MAX  = 32;
   localparam int D_MIN  = 1;
   localparam int D_MAX  = 32;
   localparam int ACC_W  = 7;
   localparam int LOCK_W = 8;

   typedef enum logic {
      LOCK_COUNT = 1'b0,
      LOCK_RUN   = 1'b1
   } lock_state_t;

   // D must absorb at least one full CLKFX period per step, otherwise one CLKIN edge would need two toggles.
   function automatic logic fx_cfg_ok(input int m, input int d);
      return (m >= M_MIN) && (m <= M_MAX) && (d >= D_MIN) && (d <= D_MAX) && (2 * m <= d);
   endfunction

endpackage

// File: rtl/dcm_sp_if.sv
// rtl/dcm_sp_if.sv - synthesized clock, clock enable, lock and status bundle
interface dcm_sp_if;

   logic       CLKFX;
   logic       CLKFX_CE;
   logic       LOCKED;
   logic [7:0] STATUS;

   modport master (output CLKFX, CLKFX_CE, LOCKED, STATUS);
   modport slave  (input  CLKFX, CLKFX_CE, LOCKED, STATUS);

endinterface

// File: rtl/dcm_fx_accum.sv
// rtl/dcm_fx_accum.sv - phase accumulator producing CLKFX and its rising-edge clock enable
module dcm_fx_accum
   import dcm_pkg::*;
#(
   parameter int MULT = 2,
   parameter int DIV  = 10
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_fx,
   output logic o_ce
);

   localparam logic [ACC_W-1:0] C_STEP = ACC_W'(2 * MULT);
   localparam logic [ACC_W-1:0] C_DIV  = ACC_W'(DIV);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_sum;
   logic             r_fx;
   logic             r_ce;

   assign w_sum = r_acc + C_STEP;

   // acc stays below DIV, so the sum never exceeds 2*DIV and fits ACC_W bits.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc <= '0;
         r_fx  <= 1'b0;
         r_ce  <= 1'b0;
      end else if (!i_en) begin
         r_acc <= '0;
         r_fx  <= 1'b0;
         r_ce  <= 1'b0;
      end else if (w_sum >= C_DIV) begin
         r_acc <= w_sum - C_DIV;
         r_fx  <= ~r_fx;
         r_ce  <= ~r_fx;
      end else begin
         r_acc <= w_sum;
         r_ce  <= 1'b0;
      end
   end

   assign o_fx = r_fx;
   assign o_ce = r_ce;

endmodule

// File: rtl/dcm_sp.sv
// rtl/dcm_sp.sv - CLKFX synthesizer top: lock sequencing, status and accumulator instance
module dcm_sp
   import dcm_pkg::*;
#(
   parameter int  CLKFX_MULTIPLY = 2,
   parameter int  CLKFX_DIVIDE   = 10,
   parameter int  LOCK_CYCLES    = 32,
   parameter real CLKIN_PERIOD   = 20.0
) (
   input  logic     CLKIN,
   input  logic     RST,
   dcm_sp_if.master fx_if
);

   localparam bit C_CFG_OK   = fx_cfg_ok(CLKFX_MULTIPLY, CLKFX_DIVIDE);
   localparam int C_LOCK_SAT = (LOCK_CYCLES < 1) ? 1 : ((LOCK_CYCLES > 255) ? 255 : LOCK_CYCLES);
   localparam logic [LOCK_W-1:0] C_LOCK = LOCK_W'(C_LOCK_SAT);

   lock_state_t       r_state;
   lock_state_t       w_state_nxt;
   logic [LOCK_W-1:0] r_cnt;
   logic [LOCK_W-1:0] w_cnt_nxt;
   logic              w_locked;
   logic              w_fx;
   logic              w_ce;
   logic              w_unused_period;

   assign w_unused_period = (CLKIN_PERIOD > 0.0);

   always_ff @(posedge CLKIN or posedge RST) begin
      if (RST) begin
         r_state <= LOCK_COUNT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // An illegal ratio parks the sequencer in LOCK_COUNT so the output never starts.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         LOCK_COUNT: begin
            if (C_CFG_OK) begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == C_LOCK - 1'b1) begin
                  w_state_nxt = LOCK_RUN;
               end
            end
         end
         LOCK_RUN: begin
            w_cnt_nxt = r_cnt;
         end
         default: begin
            w_state_nxt = LOCK_COUNT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_locked = (r_state == LOCK_RUN);

   dcm_fx_accum #(
      .MULT (CLKFX_MULTIPLY),
      .DIV  (CLKFX_DIVIDE)
   ) u_accum (
      .i_clk (CLKIN),
      .i_rst (RST),
      .i_en  (w_locked),
      .o_fx  (w_fx),
      .o_ce  (w_ce)
   );

   assign fx_if.CLKFX    = w_fx;
   assign fx_if.CLKFX_CE = w_ce;
   assign fx_if.LOCKED   = w_locked;
   assign fx_if.STATUS   = {7'd0, ~C_CFG_OK};

endmodule

// File: tb/tb_dcm_sp.sv
// tb/tb_dcm_sp.sv - self-checking bench for dcm_sp across several ratio/lock configurations
module tb_dcm_sp;

   localparam int NDUT = 5;
   localparam int PM [NDUT] = '{2, 1, 3, 6, 2};
   localparam int PD [NDUT] = '{10, 2, 7, 10, 10};
   localparam int PL [NDUT] = '{32, 32, 32, 32, 1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   k = 0;

   logic [10:0] obs [NDUT];

   dcm_sp_if if0 ();
   dcm_sp_if if1 ();
   dcm_sp_if if2 ();
   dcm_sp_if if3 ();
   dcm_sp_if if4 ();

   dcm_sp #(.CLKFX_MULTIPLY(2), .CLKFX_DIVIDE(10), .LOCK_CYCLES(32), .CLKIN_PERIOD(20.0))
      u0 (.CLKIN(clk), .RST(rst), .fx_if(if0.master));
   dcm_sp #(.CLKFX_MULTIPLY(1), .CLKFX_DIVIDE(2), .LOCK_CYCLES(32), .CLKIN_PERIOD(20.0))
      u1 (.CLKIN(clk), .RST(rst), .fx_if(if1.master));
   dcm_sp #(.CLKFX_MULTIPLY(3), .CLKFX_DIVIDE(7), .LOCK_CYCLES(32), .CLKIN_PERIOD(20.0))
      u2 (.CLKIN(clk), .RST(rst), .fx_if(if2.master));
   dcm_sp #(.CLKFX_MULTIPLY(6), .CLKFX_DIVIDE(10), .LOCK_CYCLES(32), .CLKIN_PERIOD(20.0))
      u3 (.CLKIN(clk), .RST(rst), .fx_if(if3.master));
   dcm_sp #(.CLKFX_MULTIPLY(2), .CLKFX_DIVIDE(10), .LOCK_CYCLES(1), .CLKIN_PERIOD(20.0))
      u4 (.CLKIN(clk), .RST(rst), .fx_if(if4.master));

   assign obs[0] = {if0.LOCKED, if0.CLKFX, if0.CLKFX_CE, if0.STATUS};
   assign obs[1] = {if1.LOCKED, if1.CLKFX, if1.CLKFX_CE, if1.STATUS};
   assign obs[2] = {if2.LOCKED, if2.CLKFX, if2.CLKFX_CE, if2.STATUS};
   assign obs[3] = {if3.LOCKED, if3.CLKFX, if3.CLKFX_CE, if3.STATUS};
   assign obs[4] = {if4.LOCKED, if4.CLKFX, if4.CLKFX_CE, if4.STATUS};

   always #5 clk = ~clk;

   // Total CLKFX toggles after n run edges: the ideal ratio 2*M/D, floored.
   function automatic int toggles(input int m, input int d, input int n);
      return (n <= 0) ? 0 : (2 * m * n) / d;
   endfunction

   // Expected {LOCKED, CLKFX, CLKFX_CE, STATUS} after kk CLKIN edges since reset release.
   function automatic logic [10:0] model(input int m, input int d, input int l, input int kk);
      int         n;
      int         t;
      int         tp;
      logic       lk;
      logic       fx;
      logic       ce;
      logic [7:0] st;
      bit         legal;
      legal = (m >= 1) && (m <= 32) && (d >= 1) && (d <= 32) && (2 * m <= d);
      st    = legal ? 8'h00 : 8'h01;
      n     = kk - l;
      lk    = legal && (kk >= l);
      t     = toggles(m, d, n);
      tp    = toggles(m, d, n - 1);
      fx    = lk && (t % 2 == 1);
      ce    = lk && (t != tp) && (t % 2 == 1);
      return {lk, fx, ce, st};
   endfunction

   task automatic check_all(input string tag);
      logic [10:0] e;
      for (int i = 0; i < NDUT; i++) begin
         e = model(PM[i], PD[i], PL[i], k);
         checks++;
         assert (obs[i] === e) else begin
            errors++;
            $error("FAIL %s dut%0d k=%0d observed=%h expected=%h", tag, i, k, obs[i], e);
         end
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      if (!rst) k++;
      check_all(tag);
   endtask

   int ce1_cnt = 0;
   int ce2_cnt = 0;
   int rise2_cnt = 0;
   int run2_len = 0;
   int run2_max = 0;
   logic prev2 = 1'b0;
   int n_run;
   int waited;
   logic [10:0] e0;

   initial begin
      #2;
      check_all("reset_state");
      repeat (3) step("reset_hold");
      rst = 1'b0;

      for (int it = 0; it < 3; it++) begin
         repeat (32 + $urandom_range(10, 150)) step("run");
         waited = 0;
         e0 = model(PM[0], PD[0], PL[0], k);
         while (e0[9] !== 1'b1 && waited < 20) begin
            step("seek_high");
            waited++;
            e0 = model(PM[0], PD[0], PL[0], k);
         end
         checks++;
         assert (waited < 20) else begin
            errors++;
            $error("FAIL seek_high_timeout observed=%0d expected=<20", waited);
         end
         #($urandom_range(1, 7));
         rst = 1'b1;
         k   = 0;
         #1;
         check_all("async_rst");
         repeat ($urandom_range(1, 4)) step("rst_hold");
         rst = 1'b0;
      end

      repeat (32 + 1005) begin
         step("long_run");
         n_run = k - 32;
         if (n_run >= 1 && n_run <= 1000 && if1.CLKFX_CE === 1'b1) ce1_cnt++;
         if (n_run >= 1 && n_run <= 700) begin
            if (if2.CLKFX_CE === 1'b1) ce2_cnt++;
            if (if2.CLKFX === 1'b1 && prev2 === 1'b0) rise2_cnt++;
            if (n_run == 1 || if2.CLKFX !== prev2) run2_len = 1;
            else run2_len++;
            if (run2_len > run2_max) run2_max = run2_len;
            prev2 = if2.CLKFX;
         end
      end

      checks++;
      assert (ce1_cnt === 500) else begin
         errors++;
         $error("FAIL ce_count_m1d2 observed=%0d expected=500", ce1_cnt);
      end
      checks++;
      assert (ce2_cnt === 300) else begin
         errors++;
         $error("FAIL ce_count_m3d7 observed=%0d expected=300", ce2_cnt);
      end
      checks++;
      assert (rise2_cnt === 300) else begin
         errors++;
         $error("FAIL rise_count_m3d7 observed=%0d expected=300", rise2_cnt);
      end
      checks++;
      assert (run2_max <= 2 && run2_max >= 1) else begin
         errors++;
         $error("FAIL phase_len_m3d7 observed=%0d expected=1..2", run2_max);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
